// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register-bank execution stage: command codes,
// FSM state encoding, register-file geometry and the reset-value rule.
package reg_bank_pkg;

  localparam int unsigned NumRegs      = 8;
  localparam int unsigned RegAddrW     = 3;
  localparam int unsigned CmdW         = 4;
  localparam int unsigned DefaultWidth = 32;

  localparam logic [CmdW-1:0] CmdAdd = 4'b0000;
  localparam logic [CmdW-1:0] CmdSub = 4'b0001;
  localparam logic [CmdW-1:0] CmdAnd = 4'b0010;
  localparam logic [CmdW-1:0] CmdOr  = 4'b0011;
  localparam logic [CmdW-1:0] CmdXor = 4'b0100;
  localparam logic [CmdW-1:0] CmdNot = 4'b0101;
  localparam logic [CmdW-1:0] CmdSll = 4'b1010;
  localparam logic [CmdW-1:0] CmdSrl = 4'b1011;
  localparam logic [CmdW-1:0] CmdSra = 4'b1100;
  localparam logic [CmdW-1:0] CmdSlt = 4'b1101;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StExec,
    StWb
  } state_e;

  // Any code outside the defined set executes as a NOP: no result, no writeback.
  function automatic logic is_nop(input logic [CmdW-1:0] cmd);
    case (cmd)
      CmdAdd, CmdSub, CmdAnd, CmdOr, CmdXor,
      CmdNot, CmdSll, CmdSrl, CmdSra, CmdSlt: is_nop = 1'b0;
      default:                                is_nop = 1'b1;
    endcase
  endfunction

  function automatic int unsigned reset_value(input int unsigned idx);
    return idx;
  endfunction

endpackage

// File: rtl/reg_bank_exec_if.sv
// Instruction/debug bus between the decoder (master) and reg_bank_exec (slave).
interface reg_bank_exec_if #(
  parameter int unsigned WIDTH = 32
);

  logic             start;
  logic [2:0]       A;
  logic [2:0]       B;
  logic [2:0]       Z;
  logic [3:0]       command;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [2:0]       dbg_addr;
  logic [WIDTH-1:0] dbg_data;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output start, A, B, Z, command, dbg_addr,
    input  busy, done, result, dbg_data, flag_z, flag_c, flag_v
  );

  modport slave (
    input  start, A, B, Z, command, dbg_addr,
    output busy, done, result, dbg_data, flag_z, flag_c, flag_v
  );

endinterface

// File: rtl/reg_bank_alu.sv
// Purely combinational ALU for reg_bank_exec; carry/overflow are only
// meaningful for ADD and SUB.
module reg_bank_alu
  import reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  input  logic [CmdW-1:0]  i_command,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_overflow
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [4:0]       w_shamt;
  logic             w_oversh;
  logic             w_sign_a;
  logic             w_sign_b;

  always_comb begin
    w_sum    = {1'b0, i_op_a} + {1'b0, i_op_b};
    w_diff   = {1'b0, i_op_a} - {1'b0, i_op_b};
    w_shamt  = i_op_b[4:0];
    w_oversh = (32'(w_shamt) >= WIDTH);
    w_sign_a = i_op_a[WIDTH-1];
    w_sign_b = i_op_b[WIDTH-1];

    o_result   = '0;
    o_carry    = 1'b0;
    o_overflow = 1'b0;

    case (i_command)
      CmdAdd: begin
        o_result   = w_sum[WIDTH-1:0];
        o_carry    = w_sum[WIDTH];
        o_overflow = (w_sign_a == w_sign_b) && (w_sum[WIDTH-1] != w_sign_a);
      end
      CmdSub: begin
        o_result   = w_diff[WIDTH-1:0];
        // No borrow out means A >= B unsigned.
        o_carry    = ~w_diff[WIDTH];
        o_overflow = (w_sign_a != w_sign_b) && (w_diff[WIDTH-1] != w_sign_a);
      end
      CmdAnd:  o_result = i_op_a & i_op_b;
      CmdOr:   o_result = i_op_a | i_op_b;
      CmdXor:  o_result = i_op_a ^ i_op_b;
      CmdNot:  o_result = ~i_op_a;
      CmdSll:  o_result = w_oversh ? '0 : (i_op_a << w_shamt);
      CmdSrl:  o_result = w_oversh ? '0 : (i_op_a >> w_shamt);
      CmdSra:  o_result = w_oversh ? {WIDTH{w_sign_a}} : WIDTH'($signed(i_op_a) >>> w_shamt);
      CmdSlt:  o_result[0] = ($signed(i_op_a) < $signed(i_op_b));
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/reg_bank_exec.sv
// Register-bank execution stage: 8-entry register file, four-state
// READ/EXEC/WB sequencer and debug read port. Optional flags: REG_BANK_FLAGS_EN.
module reg_bank_exec
  import reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input logic            clk,
  input logic            rst,
  reg_bank_exec_if.slave bus
);

  state_e                r_state;
  state_e                w_state_d;
  logic                  w_busy;
  logic                  w_done;
  logic [RegAddrW-1:0]   r_a;
  logic [RegAddrW-1:0]   r_b;
  logic [RegAddrW-1:0]   r_z;
  logic [CmdW-1:0]       r_cmd;
  logic [WIDTH-1:0]      r_op_a;
  logic [WIDTH-1:0]      r_op_b;
  logic [WIDTH-1:0]      r_result;
  logic [WIDTH-1:0]      r_regs [NumRegs];
  logic [WIDTH-1:0]      w_alu_result;
  logic                  w_carry;
  logic                  w_overflow;

  reg_bank_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_op_a     (r_op_a),
    .i_op_b     (r_op_b),
    .i_command  (r_cmd),
    .o_result   (w_alu_result),
    .o_carry    (w_carry),
    .o_overflow (w_overflow)
  );

  always_comb begin
    w_state_d = r_state;
    w_busy    = 1'b1;
    w_done    = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_busy = 1'b0;
        if (bus.start) w_state_d = StRead;
      end
      StRead: w_state_d = StExec;
      StExec: w_state_d = StWb;
      StWb: begin
        w_done    = 1'b1;
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_a      <= '0;
      r_b      <= '0;
      r_z      <= '0;
      r_cmd    <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
      for (int unsigned k = 0; k < NumRegs; k++) begin
        r_regs[k] <= WIDTH'(reset_value(k));
      end
    end else begin
      r_state <= w_state_d;
      if (r_state == StIdle && bus.start) begin
        r_a   <= bus.A;
        r_b   <= bus.B;
        r_z   <= bus.Z;
        r_cmd <= bus.command;
      end
      // Operands are captured before writeback, so Z may alias A or B.
      if (r_state == StRead) begin
        r_op_a <= r_regs[r_a];
        r_op_b <= r_regs[r_b];
      end
      if (r_state == StExec && !is_nop(r_cmd)) begin
        r_result <= w_alu_result;
      end
      if (r_state == StWb && !is_nop(r_cmd)) begin
        r_regs[r_z] <= r_result;
      end
    end
  end

`ifdef REG_BANK_FLAGS_EN
  logic r_flag_z;
  logic r_flag_c;
  logic r_flag_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
      r_flag_v <= 1'b0;
    end else if (r_state == StExec && !is_nop(r_cmd)) begin
      r_flag_z <= (w_alu_result == '0);
      if (r_cmd == CmdAdd || r_cmd == CmdSub) begin
        r_flag_c <= w_carry;
        r_flag_v <= w_overflow;
      end
    end
  end

  assign bus.flag_z = r_flag_z;
  assign bus.flag_c = r_flag_c;
  assign bus.flag_v = r_flag_v;
`else
  // Flags disabled: ports tied low; the ALU status bits fold away.
  assign bus.flag_z = 1'b0;
  assign bus.flag_c = w_carry & 1'b0;
  assign bus.flag_v = w_overflow & 1'b0;
`endif

  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.result   = r_result;
  assign bus.dbg_data = r_regs[bus.dbg_addr];

endmodule

// File: tb/tb_reg_bank_exec.sv
// Randomized self-checking bench for reg_bank_exec against a behavioural
// register-file/ALU model.
module tb_reg_bank_exec;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  reg_bank_exec_if #(.WIDTH(32)) bus ();

  reg_bank_exec #(
    .WIDTH (32)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] m_regs [8];
  logic [31:0] m_result;
  logic        m_fz;
  logic        m_fc;
  logic        m_fv;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_regs[k] = 32'(k);
    m_result = '0;
    m_fz = 1'b0;
    m_fc = 1'b0;
    m_fv = 1'b0;
  endtask

  function automatic bit ref_is_op(input logic [3:0] cmd);
    return (cmd <= 4'd5) || (cmd >= 4'd10 && cmd <= 4'd13);
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    sh = int'(b[4:0]);
    case (cmd)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~a;
      4'd10:   return a << sh;
      4'd11:   return a >> sh;
      4'd12:   return 32'($signed(a) >>> sh);
      4'd13:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Apply one instruction to the model: registers, result and flags.
  task automatic model_exec(input logic [2:0] a, input logic [2:0] b, input logic [2:0] z,
                            input logic [3:0] cmd);
    logic [31:0] va, vb, r;
    longint      sa, sb, ss;
    longint unsigned us;
    va = m_regs[a];
    vb = m_regs[b];
    if (!ref_is_op(cmd)) return;
    r = ref_alu(cmd, va, vb);
    m_result = r;
    m_regs[z] = r;
    m_fz = (r == 0);
    sa = longint'($signed(va));
    sb = longint'($signed(vb));
    if (cmd == 4'd0) begin
      us   = longint'(va) + longint'(vb);
      m_fc = (us >= 64'h1_0000_0000);
      ss   = sa + sb;
      m_fv = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    end else if (cmd == 4'd1) begin
      m_fc = (va >= vb);
      ss   = sa - sb;
      m_fv = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    end
  endtask

  task automatic read_dbg(input logic [2:0] addr, output logic [31:0] data);
    bus.dbg_addr = addr;
    #1;
    data = bus.dbg_data;
  endtask

  task automatic check_flags(input string tag);
`ifdef REG_BANK_FLAGS_EN
    check_value({tag, "_fz"}, 32'(bus.flag_z), 32'(m_fz));
    check_value({tag, "_fc"}, 32'(bus.flag_c), 32'(m_fc));
    check_value({tag, "_fv"}, 32'(bus.flag_v), 32'(m_fv));
`else
    check_value({tag, "_flags"}, {29'd0, bus.flag_z, bus.flag_c, bus.flag_v}, 32'd0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic sweep_regs(input string tag);
    logic [31:0] d;
    for (int k = 0; k < 8; k++) begin
      read_dbg(3'(k), d);
      check_value($sformatf("%s_reg%0d", tag, k), d, m_regs[k]);
    end
  endtask

  // Issue one instruction; optionally pulse a second start while busy.
  task automatic run_op(input logic [2:0] a, input logic [2:0] b, input logic [2:0] z,
                        input logic [3:0] cmd, input bit poke);
    logic [31:0] old_z, d;
    int          cycles;
    bit          seen;
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.Z = z;
    bus.command = cmd;
    bus.start = 1'b1;
    old_z = m_regs[z];
    @(posedge clk);
    cycles = 0;
    seen = 0;
    while (!seen && cycles < 8) begin
      @(negedge clk);
      cycles++;
      bus.start = 1'b0;
      if (poke && cycles == 1) begin
        bus.A = 3'($urandom);
        bus.Z = 3'($urandom);
        bus.command = 4'd0;
        bus.start = 1'b1;
      end
      if (bus.done) begin
        seen = 1;
        check_value("done_latency", 32'(cycles), 32'd3);
        read_dbg(z, d);
        check_value("wb_dbg_old", d, old_z);
      end else begin
        check_value("busy_in_op", 32'(bus.busy), 32'd1);
      end
    end
    if (!seen) check_value("done_timeout", 32'd0, 32'd1);
    model_exec(a, b, z, cmd);
    @(negedge clk);
    check_value("idle_busy", 32'(bus.busy), 32'd0);
    check_value("idle_done", 32'(bus.done), 32'd0);
    read_dbg(z, d);
    check_value("wb_reg", d, m_regs[z]);
    check_value("result", bus.result, m_result);
    check_flags("op");
  endtask

  initial begin
    logic [31:0] d;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.Z = '0;
    bus.command = '0;
    bus.dbg_addr = '0;

    do_reset();
    sweep_regs("reset");
    check_value("reset_busy", 32'(bus.busy), 32'd0);
    check_value("reset_done", 32'(bus.done), 32'd0);
    check_value("reset_result", bus.result, 32'd0);
    check_flags("reset");

    run_op(3'd2, 3'd3, 3'd1, 4'b0000, 1'b0);
    read_dbg(3'd1, d);
    check_value("add_r1", d, 32'd5);
    check_value("add_result", bus.result, 32'd5);

    run_op(3'd5, 3'd1, 3'd4, 4'b0001, 1'b0);
    read_dbg(3'd4, d);
    check_value("sub_r4", d, 32'd0);
`ifdef REG_BANK_FLAGS_EN
    check_value("sub_fz", 32'(bus.flag_z), 32'd1);
    check_value("sub_fc", 32'(bus.flag_c), 32'd1);
    check_value("sub_fv", 32'(bus.flag_v), 32'd0);
`endif

    run_op(3'd1, 3'd2, 3'd7, 4'b1010, 1'b1);
    read_dbg(3'd7, d);
    check_value("sll_r7", d, 32'd20);

    run_op(3'd0, 3'd0, 3'd6, 4'b1111, 1'b0);
    read_dbg(3'd6, d);
    check_value("nop_r6", d, 32'd6);
    check_value("nop_result", bus.result, 32'd20);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] cmd;
      case ($urandom_range(0, 3))
        0:       cmd = 4'($urandom_range(0, 1));
        1:       cmd = 4'($urandom_range(2, 5));
        2:       cmd = 4'($urandom_range(10, 13));
        default: cmd = 4'($urandom);
      endcase
      run_op(3'($urandom), 3'($urandom), 3'($urandom), cmd, ($urandom_range(0, 3) == 0));
    end
    sweep_regs("rand");

    // Reset while the ADD is in EXEC: no writeback, registers reloaded.
    @(negedge clk);
    bus.A = 3'd2;
    bus.B = 3'd3;
    bus.Z = 3'd1;
    bus.command = 4'b0000;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check_value("abort_busy_read", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check_value("abort_done_exec", 32'(bus.done), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_value("abort_done", 32'(bus.done), 32'd0);
    check_value("abort_busy", 32'(bus.busy), 32'd0);
    read_dbg(3'd1, d);
    check_value("abort_r1", d, 32'd1);
    check_value("abort_result", bus.result, 32'd0);
    @(negedge clk);
    check_value("abort_no_done", 32'(bus.done), 32'd0);
    sweep_regs("abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
